// File: rtl/mini_cpu_trace_buffer.sv
// Trace buffer for mini_cpu: snapshots pc/eax/ebx/mem0..mem3 on each enabled step edge
// into a FIFO that drains through a first-word-fall-through valid/ready port.
module mini_cpu_trace_buffer #(
    parameter int DEPTH = 8,
    parameter int SEQ_W = 8
) (
    input  logic                       step,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       chg_only,
    input  logic [3:0]                 pc,
    input  logic [7:0]                 eax,
    input  logic [7:0]                 ebx,
    input  logic [7:0]                 mem0,
    input  logic [7:0]                 mem1,
    input  logic [7:0]                 mem2,
    input  logic [7:0]                 mem3,
    output logic                       trc_valid,
    input  logic                       trc_ready,
    output logic [51:0]                trc_data,
    output logic [SEQ_W-1:0]           trc_seq,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       overflow,
    output logic [7:0]                 drop_cnt
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int LVL_W  = PTR_W + 1;
    localparam int DATA_W = 52;
    localparam int ENT_W  = SEQ_W + DATA_W;
    localparam logic [LVL_W-1:0] FULL = LVL_W'(DEPTH);

    logic [ENT_W-1:0]  fifo_mem [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [SEQ_W-1:0]  seq_cnt;
    logic              have_last;
    logic [DATA_W-1:0] last_snap;

    logic [DATA_W-1:0] snap;
    logic              pop;
    logic              cand;
    logic              can_push;
    logic              push;
    logic              drop;
    logic [LVL_W-1:0]  level_nxt;
    logic [LVL_W-1:0]  level_after_pop;
    logic [PTR_W-1:0]  rd_nxt;
    logic [ENT_W-1:0]  head_nxt;

    // Handshake: the head record transfers on an edge where trc_valid && trc_ready;
    // trc_valid never depends on trc_ready, and the head holds until it transfers.
    always_comb begin
        snap            = {pc, eax, ebx, mem3, mem2, mem1, mem0};
        pop             = trc_valid && trc_ready;
        cand            = en && (!chg_only || !have_last || (snap != last_snap));
        can_push        = (level != FULL) || pop;
        push            = cand && can_push;
        drop            = cand && !can_push;
        level_nxt       = level;
        if (push && !pop) begin
            level_nxt = level + 1'b1;
        end else if (pop && !push) begin
            level_nxt = level - 1'b1;
        end
        level_after_pop = pop ? (level - 1'b1) : level;
        rd_nxt          = pop ? (rd_ptr + 1'b1) : rd_ptr;
        // The output register is loaded with the next head; when the FIFO would
        // otherwise be empty that head is the record being written this edge.
        head_nxt        = '0;
        if (level_nxt != '0) begin
            if (level_after_pop == '0) begin
                head_nxt = {seq_cnt, snap};
            end else begin
                head_nxt = fifo_mem[rd_nxt];
            end
        end
    end

    always_ff @(posedge step) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {seq_cnt, snap};
        end
    end

    always_ff @(posedge step) begin
        if (rst) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            level     <= '0;
            seq_cnt   <= '0;
            have_last <= 1'b0;
            last_snap <= '0;
            overflow  <= 1'b0;
            drop_cnt  <= '0;
            trc_valid <= 1'b0;
            trc_data  <= '0;
            trc_seq   <= '0;
        end else begin
            rd_ptr <= rd_nxt;
            level  <= level_nxt;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (en) begin
                seq_cnt <= seq_cnt + 1'b1;
            end
            // Disabling capture forgets the last snapshot so re-enable always records.
            if (!en) begin
                have_last <= 1'b0;
            end else if (push) begin
                have_last <= 1'b1;
                last_snap <= snap;
            end
            if (drop) begin
                overflow <= 1'b1;
                if (drop_cnt != 8'hFF) begin
                    drop_cnt <= drop_cnt + 1'b1;
                end
            end
            trc_valid           <= (level_nxt != '0);
            {trc_seq, trc_data} <= head_nxt;
        end
    end

endmodule
